// File: rtl/approx_mult_accumulator_if.sv
// Valid/ready stream bundle between the approximate multiplier, the frame
// accumulator and the consumer of frame results.
interface approx_mult_accumulator_if #(
  parameter int PW = 33,
  parameter int AW = 40
);
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_prod;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic          out_ovf;

  modport master (
    output in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/approx_mult_accumulator.sv
// Frame accumulator for the approximate multiplier: sums FRAME_LEN unsigned
// products with saturation and presents each frame total on a held output.
module approx_mult_accumulator #(
  parameter int PW        = 33,
  parameter int AW        = 40,
  parameter int FRAME_LEN = 16,
  parameter int CW        = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  approx_mult_accumulator_if.slave     bus,
  output logic                         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  state_t        state;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          ovf;

  logic          in_ready_q;
  logic          out_valid_q;
  logic [AW-1:0] out_sum_q;
  logic          out_ovf_q;
  logic          busy_q;

  logic          accept;
  logic          last_beat;
  logic [PW-1:0] prod;
  logic [AW:0]   nsum;
  logic          beat_ovf;
  logic [AW-1:0] sat_sum;

  // clear wins over a beat in the same cycle, so the beat is simply not taken.
  assign accept    = bus.in_valid && in_ready_q && !clear;
  assign last_beat = (cnt == LAST_CNT);

  // NOTE: the product is masked to zero unless accepted, so an undriven
  // in_prod between beats can never leak X into the adder or the state.
  assign prod      = accept ? bus.in_prod : '0;
  assign nsum      = {1'b0, acc} + {{(AW + 1 - PW){1'b0}}, prod};
  assign beat_ovf  = nsum[AW];
  assign sat_sum   = beat_ovf ? {AW{1'b1}} : nsum[AW-1:0];

  // NOTE: all state lives in one clocked block using non-blocking
  // assignments; every register, including the result, has a reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE, ACCUM: begin
          if (clear) begin
            acc        <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            state      <= IDLE;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
          end else if (accept) begin
            if (last_beat) begin
              out_sum_q   <= sat_sum;
              out_ovf_q   <= ovf | beat_ovf;
              out_valid_q <= 1'b1;
              acc         <= '0;
              cnt         <= '0;
              ovf         <= 1'b0;
              state       <= HOLD;
              busy_q      <= 1'b0;
              in_ready_q  <= 1'b0;
            end else begin
              acc    <= sat_sum;
              ovf    <= ovf | beat_ovf;
              cnt    <= cnt + CW'(1);
              state  <= ACCUM;
              busy_q <= 1'b1;
            end
          end
        end

        // A completed result is never dropped: clear is ignored while held.
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          acc         <= '0;
          cnt         <= '0;
          ovf         <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = out_ovf_q;
  assign busy          = busy_q;

endmodule
